// File: rtl/apb_pkg.sv
// apb_pkg: shared phase encoding, register offsets and error bit indices for the APB register slave
package apb_pkg;
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;
    localparam logic [3:0] OFS_ID    = 4'd8;
    localparam logic [3:0] OFS_WRCNT = 4'd9;
    localparam logic [3:0] OFS_RDCNT = 4'd10;
    localparam logic [3:0] OFS_ERR   = 4'd11;
    localparam int ERR_NOSETUP = 0;
    localparam int ERR_ABORT   = 1;
    localparam int ERR_DECODE  = 2;
    function automatic logic is_mapped(input logic [3:0] ofs, input int nscr);
        return int'(ofs) < nscr || (ofs >= OFS_ID && ofs <= OFS_ERR);
    endfunction
endpackage

// File: rtl/apb_regfile_slave_if.sv
// apb_regfile_slave_if: APB bus signals between the bridge (master) and one register slave
interface apb_regfile_slave_if;
    logic [2:0]  Pselx;
    logic        Penable;
    logic        Pwrite;
    logic [31:0] Paddr;
    logic [31:0] Pwdata;
    logic [31:0] Prdata;
    logic        Perr;
    modport master (output Pselx, Penable, Pwrite, Paddr, Pwdata, input Prdata, Perr);
    modport slave  (input Pselx, Penable, Pwrite, Paddr, Pwdata, output Prdata, Perr);
endinterface

// File: rtl/apb_slave_fsm.sv
// apb_slave_fsm: APB phase tracking, setup latch and protocol checking; emits commit and error pulses
module apb_slave_fsm
    import apb_pkg::*;
(
    input  logic        Hclk,
    input  logic        Hreset,
    input  logic        sel_i,
    input  logic        penable_i,
    input  logic        pwrite_i,
    input  logic [3:0]  paddr_ofs_i,
    input  logic [31:0] pwdata_i,
    output logic        commit_wr_o,
    output logic        commit_rd_o,
    output logic        load_rd_o,
    output logic        err_nosetup_o,
    output logic        err_abort_o,
    output logic [3:0]  ofs_o,
    output logic [31:0] wdata_o
);
    state_e      state_q, state_d;
    logic        wr_q;
    logic [3:0]  ofs_q;
    logic [31:0] wdata_q;
    logic        latch, access_ok;

    // A setup request restarts the latch from any phase, including straight out of ACCESS.
    assign latch     = sel_i & ~penable_i;
    assign access_ok = state_q == SETUP && sel_i && penable_i && paddr_ofs_i == ofs_q && pwrite_i == wr_q;
    assign state_d   = latch ? SETUP : access_ok ? ACCESS : IDLE;

    always_ff @(posedge Hclk or posedge Hreset)
        if (Hreset) begin
            state_q <= IDLE;
            wr_q    <= 1'b0;
            ofs_q   <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (latch) begin
                wr_q    <= pwrite_i;
                ofs_q   <= paddr_ofs_i;
                wdata_q <= pwdata_i;
            end
        end

    assign commit_wr_o   = state_q == ACCESS && wr_q;
    assign commit_rd_o   = state_q == ACCESS && !wr_q;
    assign load_rd_o     = latch & ~pwrite_i;
    assign err_nosetup_o = sel_i & penable_i & (state_q != SETUP);
    assign err_abort_o   = state_q == SETUP && !access_ok;
    assign ofs_o         = ofs_q;
    assign wdata_o       = wdata_q;
endmodule

// File: rtl/apb_regfile_slave.sv
// apb_regfile_slave: zero-wait APB completer with scratch, ID, transfer counters and W1C error status
module apb_regfile_slave
    import apb_pkg::*;
#(
    parameter int          SEL_INDEX   = 0,
    parameter logic [31:0] ID_VALUE    = 32'hA5B0_0001,
    parameter int          NUM_SCRATCH = 8
) (
    input logic                Hclk,
    input logic                Hreset,
    apb_regfile_slave_if.slave bus
);
    logic        commit_wr, commit_rd, load_rd, err_nosetup, err_abort;
    logic [3:0]  ofs, rd_ofs;
    logic [31:0] wdata, rd_val, wrcnt_q, rdcnt_q, prdata_q;
    logic [31:0] scr_q [NUM_SCRATCH];
    logic [2:0]  err_q, err_d, err_set, err_clr;
    logic        perr_q, unused_ok;

    apb_slave_fsm u_fsm (
        .Hclk          (Hclk),
        .Hreset        (Hreset),
        .sel_i         (bus.Pselx[SEL_INDEX]),
        .penable_i     (bus.Penable),
        .pwrite_i      (bus.Pwrite),
        .paddr_ofs_i   (bus.Paddr[5:2]),
        .pwdata_i      (bus.Pwdata),
        .commit_wr_o   (commit_wr),
        .commit_rd_o   (commit_rd),
        .load_rd_o     (load_rd),
        .err_nosetup_o (err_nosetup),
        .err_abort_o   (err_abort),
        .ofs_o         (ofs),
        .wdata_o       (wdata)
    );

    assign unused_ok = ^{bus.Pselx, bus.Paddr[31:6], bus.Paddr[1:0]};

    // Read data is decoded from the live address at setup entry, using pre-edge register values.
    assign rd_ofs = bus.Paddr[5:2];
    always_comb begin
        rd_val = '0;
        for (int i = 0; i < NUM_SCRATCH; i++) rd_val = (rd_ofs == 4'(i)) ? scr_q[i] : rd_val;
        rd_val = rd_ofs == OFS_ID    ? ID_VALUE :
                 rd_ofs == OFS_WRCNT ? wrcnt_q  :
                 rd_ofs == OFS_RDCNT ? rdcnt_q  :
                 rd_ofs == OFS_ERR   ? {29'd0, err_q} : rd_val;
    end

    always_comb begin
        err_set              = '0;
        err_set[ERR_NOSETUP] = err_nosetup;
        err_set[ERR_ABORT]   = err_abort;
        err_set[ERR_DECODE]  = (commit_wr | commit_rd) & ~is_mapped(ofs, NUM_SCRATCH);
    end
    assign err_clr = (commit_wr && ofs == OFS_ERR) ? wdata[2:0] : 3'd0;
    assign err_d   = (err_q & ~err_clr) | err_set;

    always_ff @(posedge Hclk or posedge Hreset)
        if (Hreset) begin
            wrcnt_q  <= '0;
            rdcnt_q  <= '0;
            err_q    <= '0;
            perr_q   <= 1'b0;
            prdata_q <= '0;
            for (int i = 0; i < NUM_SCRATCH; i++) scr_q[i] <= '0;
        end else begin
            wrcnt_q <= wrcnt_q + 32'(commit_wr);
            rdcnt_q <= rdcnt_q + 32'(commit_rd);
            err_q   <= err_d;
            perr_q  <= |err_d;
            if (load_rd) prdata_q <= rd_val;
            for (int i = 0; i < NUM_SCRATCH; i++) if (commit_wr && ofs == 4'(i)) scr_q[i] <= wdata;
        end

    assign bus.Prdata = prdata_q;
    assign bus.Perr   = perr_q;
endmodule

// File: tb/tb_apb_regfile_slave.sv
// tb_apb_regfile_slave: directed APB transfers checked every cycle against a behavioural register-file model
module tb_apb_regfile_slave;
    import apb_pkg::*;
    localparam logic [31:0] ID = 32'hA5B0_0001;
    localparam int NS = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    apb_regfile_slave_if bus ();
    apb_regfile_slave #(.SEL_INDEX(0), .ID_VALUE(ID), .NUM_SCRATCH(NS)) dut (
        .Hclk   (clk),
        .Hreset (rst),
        .bus    (bus)
    );

    int n_chk = 0, n_fail = 0;
    logic en = 1'b0;
    logic [31:0] scr [8];
    logic [31:0] wc, rc, m_prdata, p_data, v;
    logic [2:0]  m_err;
    logic [3:0]  p_ofs;
    logic        m_perr, p_w;
    int          ph;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk)
        if (en) begin
            chk("prdata_cycle", bus.Prdata, m_prdata);
            chk("perr_cycle", {31'd0, bus.Perr}, {31'd0, m_perr});
        end

    function automatic logic [31:0] mread(input logic [3:0] o);
        if (int'(o) < NS) return scr[o[2:0]];
        if (o == 4'd8) return ID;
        if (o == 4'd9) return wc;
        if (o == 4'd10) return rc;
        if (o == 4'd11) return {29'd0, m_err};
        return 32'd0;
    endfunction

    task automatic mreset();
        for (int i = 0; i < 8; i++) scr[i] = '0;
        wc = 0; rc = 0; m_err = 0; m_perr = 0; m_prdata = 0; ph = 0;
        p_ofs = 0; p_w = 0; p_data = 0;
    endtask

    // ph: 0 idle, 1 setup, 2 access; applies the rules for the coming clock edge.
    task automatic model_edge();
        logic [31:0] rv;
        logic [2:0]  set, clr;
        logic        sel, pen;
        logic [3:0]  a;
        sel = bus.Pselx[0];
        pen = bus.Penable;
        a = bus.Paddr[5:2];
        rv = mread(a);
        set = 0;
        clr = 0;
        if (ph == 2) begin
            if (p_w) begin
                wc = wc + 1;
                if (int'(p_ofs) < NS) scr[p_ofs[2:0]] = p_data;
                if (p_ofs == 4'd11) clr = p_data[2:0];
            end else rc = rc + 1;
            if (!(int'(p_ofs) < NS || (p_ofs >= 4'd8 && p_ofs <= 4'd11))) set[2] = 1;
        end
        if (ph == 1 && !(sel && pen && a == p_ofs && bus.Pwrite == p_w)) set[1] = 1;
        if (sel && pen && ph != 1) set[0] = 1;
        if (sel && !pen) begin
            if (!bus.Pwrite) m_prdata = rv;
            p_ofs = a; p_w = bus.Pwrite; p_data = bus.Pwdata;
            ph = 1;
        end else ph = (ph == 1 && !set[1]) ? 2 : 0;
        m_err = (m_err & ~clr) | set;
        m_perr = |m_err;
    endtask

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic pins(input logic s, input logic p, input logic w, input logic [3:0] o, input logic [31:0] d);
        bus.Pselx = s ? 3'b001 : 3'b110;
        bus.Penable = p;
        bus.Pwrite = w;
        bus.Paddr = {26'($urandom), o, 2'($urandom)};
        bus.Pwdata = d;
    endtask

    task automatic drive(input logic s, input logic p, input logic w, input logic [3:0] o, input logic [31:0] d);
        pins(s, p, w, o, d);
        model_edge();
        cyc();
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0);
    endtask

    task automatic wr(input logic [3:0] o, input logic [31:0] d, input bit b2b = 0);
        drive(1, 0, 1, o, d);
        drive(1, 1, 1, o, d);
        if (!b2b) idle();
    endtask

    task automatic rd(input logic [3:0] o, output logic [31:0] val, input bit b2b = 0);
        drive(1, 0, 0, o, 0);
        drive(1, 1, 0, o, 0);
        val = bus.Prdata;
        if (!b2b) idle();
    endtask

    task automatic do_reset();
        pins(0, 0, 0, 0, 0);
        rst = 1;
        mreset();
        cyc();
        rst = 0;
    endtask

    initial begin
        pins(0, 0, 0, 0, 0);
        mreset();
        en = 1;
        cyc();
        cyc();
        chk("reset_prdata", bus.Prdata, 32'h0);
        chk("reset_perr", {31'd0, bus.Perr}, 32'h0);
        rst = 0;
        idle();
        // write then read a scratch register
        wr(3, 32'hDEADBEEF);
        rd(3, v);
        chk("rd_scr3", v, 32'hDEADBEEF);
        chk("model_scr3", m_prdata, 32'hDEADBEEF);
        rd(10, v);
        chk("rdcnt_1", v, 32'd1);
        rd(9, v);
        chk("wrcnt_1", v, 32'd1);
        chk("perr_clean", {31'd0, bus.Perr}, 32'h0);
        // ID is read-only
        do_reset();
        rd(8, v);
        chk("rd_id", v, ID);
        wr(8, 32'h0);
        rd(8, v);
        chk("rd_id_after_wr", v, ID);
        rd(9, v);
        chk("wrcnt_ro", v, 32'd1);
        // back-to-back writes and reads
        do_reset();
        wr(0, 32'h1111_0000, 1);
        wr(1, 32'h2222_0001, 1);
        wr(2, 32'h3333_0002);
        rd(0, v, 1);
        chk("b2b_scr0", v, 32'h1111_0000);
        rd(1, v, 1);
        chk("b2b_scr1", v, 32'h2222_0001);
        rd(2, v);
        chk("b2b_scr2", v, 32'h3333_0002);
        rd(9, v);
        chk("wrcnt_3", v, 32'd3);
        // enable without setup, then W1C
        do_reset();
        drive(1, 1, 0, 0, 0);
        chk("perr_nosetup", {31'd0, bus.Perr}, 32'h1);
        idle();
        rd(11, v);
        chk("err_bit0", v, 32'h1);
        wr(11, 32'h1);
        rd(11, v);
        chk("err_cleared", v, 32'h0);
        chk("perr_cleared", {31'd0, bus.Perr}, 32'h0);
        // setup/access mismatch and decode error
        do_reset();
        drive(1, 0, 1, 2, 32'h55);
        drive(1, 1, 1, 4, 32'h55);
        idle();
        rd(2, v);
        chk("mismatch_scr2", v, 32'h0);
        rd(4, v);
        chk("mismatch_scr4", v, 32'h0);
        rd(11, v);
        chk("err_bit1", v, 32'h2);
        rd(14, v);
        chk("rd_unmapped", v, 32'h0);
        rd(11, v);
        chk("err_bit12", v, 32'h6);
        // W1C clear and bit0 set on the same edge: set wins
        drive(1, 0, 1, 11, 32'h7);
        drive(1, 1, 1, 11, 32'h7);
        drive(1, 1, 1, 11, 32'h7);
        idle();
        rd(11, v);
        chk("set_wins", v, 32'h1);
        wr(11, 32'h7);
        drive(1, 0, 0, 5, 0);
        wr(6, 32'h77);
        rd(6, v);
        chk("restart_scr6", v, 32'h77);
        rd(11, v);
        chk("err_restart", v, 32'h2);
        // reset during a write access
        do_reset();
        drive(1, 0, 1, 0, 32'h1234);
        pins(1, 1, 1, 0, 32'h1234);
        rst = 1;
        mreset();
        cyc();
        chk("midrst_prdata", bus.Prdata, 32'h0);
        chk("midrst_state", 32'(dut.u_fsm.state_q), 32'(IDLE));
        rst = 0;
        idle();
        rd(0, v);
        chk("midrst_scr0", v, 32'h0);
        rd(9, v);
        chk("midrst_wrcnt", v, 32'h0);
        en = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
